cart_bus_master: RTL and testbench

- Sequences single read/write transactions on one bidirectional cartridge data bank with programmable setup/strobe/hold/turnaround timing.
- Sits directly upstream of the bidirectional port interface: drives its direction select and outbound data, and consumes its inbound data.
- Core logic issues requests over a valid/ready handshake and receives a one-cycle response pulse.
- Guarantees the bank is never driven during the turnaround window after a write.

---
 rtl/cart_bus_master.sv | 171 +++++++++++++++++
 tb/tb_cart_bus_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_bus_master.sv
// Single-transaction sequencer for a bidirectional cartridge data bank with setup/strobe/hold/turnaround timing.
// Define CART_BUS_SYNC_EN to route from_port through a 2-flop synchroniser and stretch the strobe by 2 cycles.
module cart_bus_master #(
    parameter int DATA_W        = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int TURN_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              dir_to_port,
    output logic [DATA_W-1:0] to_port,
    input  logic [DATA_W-1:0] from_port,
    output logic              strobe_n,
    output logic              busy
);

`ifdef CART_BUS_SYNC_EN
    localparam int STROBE_LEN = STROBE_CYCLES + 2;
`else
    localparam int STROBE_LEN = STROBE_CYCLES;
`endif
    localparam int MAX_A   = (SETUP_CYCLES > STROBE_LEN) ? SETUP_CYCLES : STROBE_LEN;
    localparam int MAX_B   = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1 || TURN_CYCLES < 1) begin : g_bad_param
        $error("cart_bus_master: all timing parameters must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                dir_q, dir_d;
    logic [DATA_W-1:0]   to_port_q, to_port_d;
    logic                strobe_n_q, strobe_n_d;
    logic                last;
    logic [DATA_W-1:0]   cap_data;

`ifdef CART_BUS_SYNC_EN
    logic [DATA_W-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= from_port;
            sync2_q <= sync1_q;
        end
    end

    assign cap_data = sync2_q;
`else
    assign cap_data = from_port;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        last        = (cnt_q == CNT_W'(1));

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(SETUP_CYCLES);
                    wr_d    = req_write;
                    wdata_d = req_wdata;
                end
            end
            SETUP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d = STROBE;
                    cnt_d   = CNT_W'(STROBE_LEN);
                end
            end
            STROBE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES);
                    if (!wr_q) rsp_rdata_d = cap_data;
                end
            end
            HOLD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    rsp_valid_d = 1'b1;
                    if (wr_q) begin
                        state_d     = TURN;
                        cnt_d       = CNT_W'(TURN_CYCLES);
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TURN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so every port comes straight off a flop.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        strobe_n_d  = (state_d != STROBE);
        dir_d       = wr_d && (state_d == SETUP || state_d == STROBE || state_d == HOLD);
        to_port_d   = dir_d ? wdata_d : '0;
    end

    // NOTE: every flop updates with <= so all of them sample pre-edge values consistently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            dir_q       <= 1'b0;
            to_port_q   <= '0;
            strobe_n_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            dir_q       <= dir_d;
            to_port_q   <= to_port_d;
            strobe_n_q  <= strobe_n_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign dir_to_port = dir_q;
    assign to_port     = to_port_q;
    assign strobe_n    = strobe_n_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// Self-checking bench for cart_bus_master (default build): per-cycle expectations come from a
// transaction-level timeline model indexed by cycle number.
module tb_cart_bus_master;
    localparam int DW = 8;
    localparam int S  = 2;
    localparam int ST = 4;
    localparam int H  = 1;
    localparam int T  = 2;
    localparam int N  = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_write;
    logic [DW-1:0] req_wdata, from_port;
    logic          req_ready, rsp_valid, dir_to_port, strobe_n, busy;
    logic [DW-1:0] rsp_rdata, to_port;

    cart_bus_master #(
        .DATA_W(DW), .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H), .TURN_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .dir_to_port(dir_to_port), .to_port(to_port), .from_port(from_port),
        .strobe_n(strobe_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stimulus and expectation timelines, one entry per cycle.
    bit            in_rst [N];
    bit            in_v   [N];
    bit            in_w   [N];
    logic [DW-1:0] in_d   [N];
    logic [DW-1:0] in_fp  [N];
    bit            e_ready[N];
    bit            e_dir  [N];
    bit            e_sn   [N];
    bit            e_rsp  [N];
    logic [DW-1:0] e_to   [N];
    logic [DW-1:0] e_rd   [N];

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [20:0] obs, expv;

    function automatic void set_idle(int from, int to);
        for (int c = from; c < to && c < N; c++) begin
            in_rst[c]  = 1'b0;
            in_v[c]    = 1'b0;
            in_w[c]    = 1'b0;
            in_d[c]    = DW'($urandom);
            in_fp[c]   = DW'($urandom);
            e_ready[c] = 1'b1;
            e_dir[c]   = 1'b0;
            e_sn[c]    = 1'b1;
            e_rsp[c]   = 1'b0;
            e_to[c]    = '0;
            e_rd[c]    = '0;
        end
    endfunction

    // Request presented in cycle a; returns the first cycle the block can accept again.
    function automatic int schedule(int a, bit w, logic [DW-1:0] wd, logic [DW-1:0] rd);
        int r;
        int busy_end;
        r        = a + S + ST + H + 1;
        busy_end = w ? r + T : r;
        in_v[a] = 1'b1;
        in_w[a] = w;
        in_d[a] = wd;
        for (int c = a + 1; c < busy_end; c++) e_ready[c] = 1'b0;
        for (int c = a + S + 1; c <= a + S + ST; c++) begin
            e_sn[c]  = 1'b0;
            in_fp[c] = rd;
        end
        if (w) begin
            for (int c = a + 1; c < r; c++) begin
                e_dir[c] = 1'b1;
                e_to[c]  = wd;
            end
        end
        e_rsp[r] = 1'b1;
        e_rd[r]  = w ? '0 : rd;
        return busy_end;
    endfunction

    task automatic drive(int c);
        reset     = in_rst[c];
        req_valid = in_v[c];
        req_write = in_w[c];
        req_wdata = in_d[c];
        from_port = in_fp[c];
    endtask

    task automatic test_reset();
        set_idle(0, 40);
        in_rst[0] = 1'b1;
        in_rst[1] = 1'b1;
        for (int c = cyc; c < 8; c++) begin
            @(negedge clk);
            obs  = {req_ready, busy, dir_to_port, to_port, strobe_n, rsp_valid, rsp_rdata};
            expv = {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h, expected %h", c, obs, expv);
            end
            drive(c);
        end
        cyc = 8;
    endtask

    task automatic test_write();
        int stop;
        set_idle(cyc, cyc + 40);
        stop = schedule(cyc + 1, 1'b1, 8'hA5, 8'h00) + 2;
        for (int c = cyc; c < stop; c++) begin
            @(negedge clk);
            obs  = {req_ready, busy, dir_to_port, to_port, strobe_n, rsp_valid, rsp_valid ? rsp_rdata : 8'h00};
            expv = {e_ready[c], !e_ready[c], e_dir[c], e_to[c], e_sn[c], e_rsp[c], e_rsp[c] ? e_rd[c] : 8'h00};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL write_a5 cycle %0d: got %h, expected %h", c, obs, expv);
            end
            drive(c);
        end
        cyc = stop;
    endtask

    task automatic test_read();
        int a, stop;
        a = cyc + 1;
        set_idle(cyc, cyc + 40);
        for (int c = cyc; c < cyc + 40; c++) in_fp[c] = 8'hFF;
        stop = schedule(a, 1'b0, 8'h00, 8'h3C) + 2;
        for (int c = cyc; c < stop; c++) begin
            @(negedge clk);
            obs  = {req_ready, busy, dir_to_port, to_port, strobe_n, rsp_valid, rsp_valid ? rsp_rdata : 8'h00};
            expv = {e_ready[c], !e_ready[c], e_dir[c], e_to[c], e_sn[c], e_rsp[c], e_rsp[c] ? e_rd[c] : 8'h00};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL read_3c cycle %0d: got %h, expected %h", c, obs, expv);
            end
            drive(c);
        end
        cyc = stop;
    endtask

    task automatic test_back_to_back();
        int a, nxt, stop, pulses;
        a = cyc + 1;
        pulses = 0;
        set_idle(cyc, cyc + 60);
        nxt  = schedule(a, 1'b0, 8'h00, 8'h96);
        stop = schedule(nxt, 1'b0, 8'h00, 8'hC3) + 4;
        for (int c = cyc; c < stop; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
            obs  = {req_ready, busy, dir_to_port, to_port, strobe_n, rsp_valid, rsp_valid ? rsp_rdata : 8'h00};
            expv = {e_ready[c], !e_ready[c], e_dir[c], e_to[c], e_sn[c], e_rsp[c], e_rsp[c] ? e_rd[c] : 8'h00};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h, expected %h", c, obs, expv);
            end
            drive(c);
        end
        cyc = stop;
        n_tests++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d, expected 2", pulses);
        end
        n_tests++;
        if (rsp_rdata !== 8'hC3) begin
            n_fail++;
            $display("FAIL rdata_hold: got %h, expected c3", rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int a, stop;
        a = cyc + 1;
        set_idle(cyc, cyc + 40);
        void'(schedule(a, 1'b1, 8'h5E, 8'h00));
        set_idle(a + 5, a + 40);
        in_rst[a + 4] = 1'b1;
        stop = a + 16;
        for (int c = cyc; c < stop; c++) begin
            @(negedge clk);
            obs  = {req_ready, busy, dir_to_port, to_port, strobe_n, rsp_valid, rsp_valid ? rsp_rdata : 8'h00};
            expv = {e_ready[c], !e_ready[c], e_dir[c], e_to[c], e_sn[c], e_rsp[c], e_rsp[c] ? e_rd[c] : 8'h00};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_mid_write cycle %0d: got %h, expected %h", c, obs, expv);
            end
            drive(c);
        end
        cyc = stop;
        n_tests++;
        if (rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_clears_rdata: got %h, expected 00", rsp_rdata);
        end
    endtask

    task automatic test_random();
        int nxt, a, stop;
        nxt = cyc + 1;
        set_idle(cyc, cyc + 900);
        for (int k = 0; k < 40; k++) begin
            a   = nxt + $urandom_range(0, 3);
            nxt = schedule(a, 1'($urandom), DW'($urandom), DW'($urandom));
            // Requests presented while busy must be ignored.
            for (int c = a + 1; c < nxt; c++) begin
                in_v[c] = 1'($urandom);
                in_w[c] = 1'($urandom);
            end
        end
        stop = nxt + 3;
        for (int c = cyc; c < stop; c++) begin
            @(negedge clk);
            obs  = {req_ready, busy, dir_to_port, to_port, strobe_n, rsp_valid, rsp_valid ? rsp_rdata : 8'h00};
            expv = {e_ready[c], !e_ready[c], e_dir[c], e_to[c], e_sn[c], e_rsp[c], e_rsp[c] ? e_rd[c] : 8'h00};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random_traffic cycle %0d: got %h, expected %h", c, obs, expv);
            end
            drive(c);
        end
        cyc = stop;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = '0;
        from_port = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
